// File: rtl/canny_hyst_pkg.sv
// canny_hyst_pkg: shared pixel class type, pipeline latency and the
// din -> class mapping used by the hysteresis stage.
package canny_hyst_pkg;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_WEAK   = 2'd1,
    CLS_STRONG = 2'd2
  } cls_t;

  // Input cycle t appears on dout/hsync/fsync at cycle t+LAT.
  localparam int LAT = 3;

  // Widest pixel the classify helper accepts; callers zero-extend.
  localparam int MAX_DW = 32;

  // Anything that is neither the strong nor the weak code is NONE.
  function automatic cls_t classify(input logic [MAX_DW-1:0] pix,
                                    input logic [MAX_DW-1:0] strong_code,
                                    input logic [MAX_DW-1:0] weak_code);
    cls_t res;
    res = CLS_NONE;
    if (pix == strong_code) begin
      res = CLS_STRONG;
    end else if (pix == weak_code) begin
      res = CLS_WEAK;
    end
    return res;
  endfunction

endpackage

// File: rtl/hyst_line_buf.sv
// hyst_line_buf: two rows of pixel classes (row r-1 and row r-2) sharing one
// address. Reads are combinational so the old contents are seen in the same
// cycle as the write; the r-1 row shifts down into r-2 as the new class lands.
// Addresses at or beyond 2^AW (overlong lines) never write, so the first
// 2^AW columns of the stored rows survive an overflowing line.
module hyst_line_buf
  import canny_hyst_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic        clk,
  input  logic        we,
  input  logic [AW:0] addr,
  input  cls_t        wdata,
  output cls_t        rd_r1,
  output cls_t        rd_r2
);

  localparam int DEPTH = 1 << AW;

  cls_t lb1 [DEPTH];
  cls_t lb2 [DEPTH];

  logic          in_range;
  logic [AW-1:0] a;

  assign in_range = (addr[AW] == 1'b0);
  assign a        = addr[AW-1:0];

  assign rd_r1 = lb1[a];
  assign rd_r2 = lb2[a];

  // Read-before-write: row r-1 moves to r-2 while the current class becomes r-1.
  always_ff @(posedge clk) begin
    if (we && in_range) begin
      lb1[a] <= wdata;
      lb2[a] <= lb1[a];
    end
  end

endmodule

// File: rtl/canny_hysteresis.sv
// canny_hysteresis: single-pass 8-neighbour hysteresis on a classified pixel
// stream (strong / weak / suppressed). Strong centres become edges; weak
// centres become edges when any 3x3 neighbour is strong. Three register
// stages: classify + position, line buffer + window, decision.
// The 3x3 centre is (row-1, col-1), so the edge map is shifted by one row and
// one column relative to the input raster; row 0 / column 0 are forced to 0.
// Optional build macro HYST_STATS_EN adds per-frame strong/promoted counters
// (n_strong, n_promoted, stats_vld).
module canny_hysteresis
  import canny_hyst_pkg::*;
#(
  parameter int            DW          = 8,
  parameter int            AW          = 10,
  parameter logic [DW-1:0] STRONG_CODE = 8'hFF,
  parameter logic [DW-1:0] WEAK_CODE   = 8'h80,
  parameter logic [DW-1:0] EDGE_VAL    = 8'hFF
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          hvalid,
  input  logic          vvalid,
  input  logic [DW-1:0] din,
  output logic          hsync,
  output logic          fsync,
  output logic [DW-1:0] dout
`ifdef HYST_STATS_EN
  ,
  output logic [31:0]   n_strong,
  output logic [31:0]   n_promoted,
  output logic          stats_vld
`endif
);

  // rst_b is active-high: 1 holds the block in reset.

  logic        armed;
  logic        hv_g;
  logic        vv_g;
  logic        hv_prev;
  logic [AW:0] col_cnt;
  logic [AW:0] row_cnt;

  cls_t        s0_cls;
  logic        s0_hv;
  logic        s0_vv;
  logic [AW:0] s0_col;
  logic [AW:0] s0_row;

  cls_t        lb_r1;
  cls_t        lb_r2;

  cls_t        win [3][3];
  logic        s1_hv;
  logic        s1_vv;
  logic        s1_ok;

  logic        nbr_strong;
  logic        is_strong;
  logic        is_prom;

  // After a reset the input may still be mid-frame; ignore it until a
  // frame gap (vvalid low) so a partial frame is never emitted as valid.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      armed <= 1'b0;
    end else if (!vvalid) begin
      armed <= 1'b1;
    end
  end

  assign hv_g = hvalid & armed;
  assign vv_g = vvalid & armed;

  // Raster position of the pixel currently on din; both counters saturate.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      col_cnt <= '0;
      row_cnt <= '0;
      hv_prev <= 1'b0;
    end else begin
      hv_prev <= hv_g;
      if (!vv_g) begin
        col_cnt <= '0;
        row_cnt <= '0;
      end else begin
        if (hv_g) begin
          if (col_cnt != '1) begin
            col_cnt <= col_cnt + (AW+1)'(1);
          end
        end else begin
          col_cnt <= '0;
        end
        if (hv_prev && !hv_g && (row_cnt != '1)) begin
          row_cnt <= row_cnt + (AW+1)'(1);
        end
      end
    end
  end

  // Stage 0: classify the pixel and capture its position and framing.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      s0_cls <= CLS_NONE;
      s0_hv  <= 1'b0;
      s0_vv  <= 1'b0;
      s0_col <= '0;
      s0_row <= '0;
    end else begin
      s0_cls <= hv_g ? classify(MAX_DW'(din), MAX_DW'(STRONG_CODE), MAX_DW'(WEAK_CODE))
                     : CLS_NONE;
      s0_hv  <= hv_g;
      s0_vv  <= vv_g;
      s0_col <= col_cnt;
      s0_row <= row_cnt;
    end
  end

  hyst_line_buf #(
    .AW(AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (s0_hv),
    .addr  (s0_col),
    .wdata (s0_cls),
    .rd_r1 (lb_r1),
    .rd_r2 (lb_r2)
  );

  // Stage 1: shift the 3x3 window (win[row][col], row 0 = current line,
  // col 0 = newest column) and decide whether its centre is a legal output.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win[i][j] <= CLS_NONE;
        end
      end
      s1_hv <= 1'b0;
      s1_vv <= 1'b0;
      s1_ok <= 1'b0;
    end else begin
      if (s0_hv) begin
        for (int i = 0; i < 3; i++) begin
          win[i][2] <= win[i][1];
          win[i][1] <= win[i][0];
        end
        win[0][0] <= s0_cls;
        win[1][0] <= lb_r1;
        win[2][0] <= lb_r2;
      end
      s1_hv <= s0_hv;
      s1_vv <= s0_vv;
      // Rows 0/1 and cols 0/1 would pull in stale line-buffer or window data.
      s1_ok <= s0_hv && (s0_row >= (AW+1)'(2)) && (s0_col >= (AW+1)'(2))
               && !s0_col[AW];
    end
  end

  // Hysteresis rule on the window centre.
  always_comb begin
    nbr_strong = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (!((i == 1) && (j == 1)) && (win[i][j] == CLS_STRONG)) begin
          nbr_strong = 1'b1;
        end
      end
    end
    is_strong = (win[1][1] == CLS_STRONG);
    is_prom   = (win[1][1] == CLS_WEAK) && nbr_strong;
  end

`ifdef HYST_STATS_EN
  logic s2_strong;
  logic s2_prom;
`endif

  // Stage 2: registered edge decision and delayed framing.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      hsync     <= 1'b0;
      fsync     <= 1'b0;
      dout      <= '0;
`ifdef HYST_STATS_EN
      s2_strong <= 1'b0;
      s2_prom   <= 1'b0;
`endif
    end else begin
      hsync     <= s1_hv;
      fsync     <= s1_vv;
      dout      <= (s1_ok && (is_strong || is_prom)) ? EDGE_VAL : '0;
`ifdef HYST_STATS_EN
      s2_strong <= s1_ok && is_strong;
      s2_prom   <= s1_ok && is_prom;
`endif
    end
  end

`ifdef HYST_STATS_EN
  logic        fsync_d;
  logic [31:0] cnt_strong;
  logic [31:0] cnt_prom;

  // Per-frame counts aligned with the output framing; published at frame end.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      fsync_d    <= 1'b0;
      cnt_strong <= '0;
      cnt_prom   <= '0;
      n_strong   <= '0;
      n_promoted <= '0;
      stats_vld  <= 1'b0;
    end else begin
      fsync_d   <= fsync;
      stats_vld <= 1'b0;
      if (fsync && !fsync_d) begin
        cnt_strong <= 32'(s2_strong);
        cnt_prom   <= 32'(s2_prom);
      end else if (fsync) begin
        cnt_strong <= cnt_strong + 32'(s2_strong);
        cnt_prom   <= cnt_prom + 32'(s2_prom);
      end
      if (!fsync && fsync_d) begin
        n_strong   <= cnt_strong;
        n_promoted <= cnt_prom;
        stats_vld  <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_canny_hysteresis.sv
// Bench for canny_hysteresis: two instances (AW=10 and AW=4) share one input
// stream; a raster-level model predicts each output three cycles later.
module tb_canny_hysteresis;

  localparam int AW_A = 10;
  localparam int AW_B = 4;
  localparam logic [7:0] S = 8'hFF;
  localparam logic [7:0] W = 8'h80;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       hvalid;
  logic       vvalid;
  logic [7:0] din;
  logic       hs_a, fs_a, hs_b, fs_b;
  logic [7:0] dout_a, dout_b;
`ifdef HYST_STATS_EN
  logic [31:0] ns_a, np_a, ns_b, np_b;
  logic        sv_a, sv_b;
`endif

  always #5 clk = ~clk;

  canny_hysteresis #(
    .DW(8), .AW(AW_A), .STRONG_CODE(8'hFF), .WEAK_CODE(8'h80), .EDGE_VAL(8'hFF)
  ) dut_a (
    .clk(clk), .rst_b(rst_b), .hvalid(hvalid), .vvalid(vvalid), .din(din),
    .hsync(hs_a), .fsync(fs_a), .dout(dout_a)
`ifdef HYST_STATS_EN
    , .n_strong(ns_a), .n_promoted(np_a), .stats_vld(sv_a)
`endif
  );

  canny_hysteresis #(
    .DW(8), .AW(AW_B), .STRONG_CODE(8'hFF), .WEAK_CODE(8'h80), .EDGE_VAL(8'hFF)
  ) dut_b (
    .clk(clk), .rst_b(rst_b), .hvalid(hvalid), .vvalid(vvalid), .din(din),
    .hsync(hs_b), .fsync(fs_b), .dout(dout_b)
`ifdef HYST_STATS_EN
    , .n_strong(ns_b), .n_promoted(np_b), .stats_vld(sv_b)
`endif
  );

  typedef struct packed {
    logic       hs;
    logic       fs;
    logic [7:0] da;
    logic [7:0] db;
  } exp_t;

  int checks = 0;
  int failures = 0;

  logic [7:0] pix [0:15][0:31];
  int         cls_img [0:15][0:31];
  int         m_row, m_col;
  bit         m_prev_hv, m_prev_vv, m_armed;
  int         run_s [2];
  int         run_p [2];
  int         last_s [2];
  int         last_p [2];
  int         m_pulses;
  exp_t       q [$];
  int         edges [2];
  int         pulses [2];
  int         cyc, rst_at, rst_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int cls_of(input logic [7:0] d);
    if (d == 8'hFF) return 2;
    if (d == 8'h80) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_row = 0; m_col = 0;
    m_prev_hv = 1'b0; m_prev_vv = 1'b0; m_armed = 1'b0;
    for (int k = 0; k < 2; k++) begin
      run_s[k] = 0; run_p[k] = 0; last_s[k] = 0; last_p[k] = 0;
    end
  endtask

  // Raster model: keeps the frame's classes as an image and evaluates the
  // 3x3 neighbourhood centred one row up and one column left of the input.
  task automatic model_step(input bit hv, input bit vv, input logic [7:0] d, output exp_t e);
    bit hg, vg, strong_c, prom_c, nb, ok;
    int r, c, centre;
    int aw [2];
    aw[0] = AW_A; aw[1] = AW_B;
    hg = hv && m_armed;
    vg = vv && m_armed;
    r = m_row; c = m_col;
    e = '0;
    e.hs = hg;
    e.fs = vg;
    if (hg && r < 16 && c < 32) cls_img[r][c] = cls_of(d);
    strong_c = 1'b0; prom_c = 1'b0;
    if (hg && r >= 2 && c >= 2) begin
      centre = cls_img[r-1][c-1];
      nb = 1'b0;
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++)
          if ((dr != 0 || dc != 0) && cls_img[r-1+dr][c-1+dc] == 2) nb = 1'b1;
      strong_c = (centre == 2);
      prom_c   = (centre == 1) && nb;
    end
    if (vg && !m_prev_vv) begin
      run_s[0] = 0; run_s[1] = 0; run_p[0] = 0; run_p[1] = 0;
    end
    for (int k = 0; k < 2; k++) begin
      ok = (c < (1 << aw[k]));
      if (ok && (strong_c || prom_c)) begin
        if (k == 0) e.da = 8'hFF; else e.db = 8'hFF;
      end
      if (ok && vg) begin
        run_s[k] += int'(strong_c);
        run_p[k] += int'(prom_c);
      end
    end
    if (!vg && m_prev_vv) begin
      for (int k = 0; k < 2; k++) begin
        last_s[k] = run_s[k]; last_p[k] = run_p[k];
      end
      m_pulses++;
    end
    if (!vg) begin
      m_row = 0; m_col = 0;
    end else begin
      if (m_prev_hv && !hg) m_row++;
      m_col = hg ? m_col + 1 : 0;
    end
    m_prev_hv = hg;
    m_prev_vv = vg;
    if (!vv) m_armed = 1'b1;
  endtask

  task automatic step(input bit hv, input bit vv, input logic [7:0] d);
    exp_t e, f;
    if (cyc == rst_at) rst_left = 3;
    @(negedge clk);
    hvalid = hv; vvalid = vv; din = d;
    if (rst_left > 0) begin
      if (rst_left == 3) begin
        rst_b = 1'b1;
        #1;
        chk("rst_mid_dout_a", 32'(dout_a), 32'h0);
        chk("rst_mid_hsync_a", 32'(hs_a), 32'h0);
        chk("rst_mid_fsync_a", 32'(fs_a), 32'h0);
        chk("rst_mid_dout_b", 32'(dout_b), 32'h0);
        chk("rst_mid_hsync_b", 32'(hs_b), 32'h0);
        chk("rst_mid_fsync_b", 32'(fs_b), 32'h0);
        q.delete();
        q.push_back('0);
        q.push_back('0);
        model_reset();
      end
      rst_left--;
      e = '0;
    end else begin
      rst_b = 1'b0;
      model_step(hv, vv, d, e);
    end
    q.push_back(e);
    cyc++;
    @(posedge clk);
    #1;
    if (q.size() >= 3) begin
      f = q.pop_front();
      chk("hsync_a", 32'(hs_a), 32'(f.hs));
      chk("fsync_a", 32'(fs_a), 32'(f.fs));
      chk("dout_a", 32'(dout_a), 32'(f.da));
      chk("hsync_b", 32'(hs_b), 32'(f.hs));
      chk("fsync_b", 32'(fs_b), 32'(f.fs));
      chk("dout_b", 32'(dout_b), 32'(f.db));
    end
    if (dout_a == 8'hFF) edges[0]++;
    if (dout_b == 8'hFF) edges[1]++;
`ifdef HYST_STATS_EN
    if (sv_a) begin
      pulses[0]++;
      chk("n_strong_a", ns_a, 32'(last_s[0]));
      chk("n_promoted_a", np_a, 32'(last_p[0]));
    end
    if (sv_b) begin
      pulses[1]++;
      chk("n_strong_b", ns_b, 32'(last_s[1]));
      chk("n_promoted_b", np_b, 32'(last_p[1]));
    end
`endif
  endtask

  task automatic run_frame(input int w, input int h, input bit abort);
    edges[0] = 0; edges[1] = 0;
    rst_at = abort ? (cyc + 2 + 3 * (w + 3) + w / 2) : -1;
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) step(1'b1, 1'b1, pix[r][c]);
      for (int g = 0; g < 3; g++) step(1'b0, 1'b1, 8'h00);
    end
    for (int g = 0; g < 8; g++) step(1'b0, 1'b0, 8'h00);
`ifdef HYST_STATS_EN
    chk("stats_pulses_a", 32'(pulses[0]), 32'(m_pulses));
    chk("stats_pulses_b", 32'(pulses[1]), 32'(m_pulses));
`endif
  endtask

  task automatic clear_pix();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 32; c++) pix[r][c] = 8'h00;
  endtask

  task automatic rand_frame(output int w, output int h);
    int x, v;
    w = $urandom_range(6, 24);
    h = $urandom_range(4, 10);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 32; c++) begin
        x = $urandom_range(0, 99);
        if (x < 12) pix[r][c] = S;
        else if (x < 32) pix[r][c] = W;
        else begin
          v = $urandom_range(0, 254);
          if (v == 8'h80) v = 0;
          pix[r][c] = 8'(v);
        end
      end
    end
  endtask

  initial begin
    int w, h;
    rst_b = 1'b1; hvalid = 1'b0; vvalid = 1'b0; din = 8'h00;
    cyc = 0; rst_at = -1; rst_left = 0; m_pulses = 0;
    pulses[0] = 0; pulses[1] = 0; edges[0] = 0; edges[1] = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 32; c++) cls_img[r][c] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout_a", 32'(dout_a), 32'h0);
    chk("reset_hsync_a", 32'(hs_a), 32'h0);
    chk("reset_fsync_a", 32'(fs_a), 32'h0);
    chk("reset_dout_b", 32'(dout_b), 32'h0);
`ifdef HYST_STATS_EN
    chk("reset_n_strong", ns_a, 32'h0);
    chk("reset_stats_vld", 32'(sv_a), 32'h0);
`endif
    repeat (4) step(1'b0, 1'b0, 8'h00);

    // isolated strong pixel
    clear_pix();
    pix[3][5] = S;
    run_frame(16, 8, 1'b0);
    chk("iso_edges_a", 32'(edges[0]), 32'd1);
    chk("iso_edges_b", 32'(edges[1]), 32'd1);

    // weak promotion: adjacent, isolated, diagonal; plus a lone strong
    clear_pix();
    pix[3][4] = W;  pix[3][5] = S;
    pix[6][10] = W;
    pix[5][12] = S; pix[4][11] = W;
    pix[2][8] = S;
    run_frame(16, 8, 1'b0);
    chk("weak_edges_a", 32'(edges[0]), 32'd5);
    chk("weak_edges_b", 32'(edges[1]), 32'd5);
`ifdef HYST_STATS_EN
    chk("weak_n_strong", ns_a, 32'd3);
    chk("weak_n_promoted", np_a, 32'd2);
`endif

    // border: first row/column and last row/column never produce edges
    clear_pix();
    pix[0][3] = S; pix[3][0] = S; pix[7][5] = S; pix[4][15] = S;
    run_frame(16, 8, 1'b0);
    chk("border_edges_a", 32'(edges[0]), 32'd0);
    chk("border_edges_b", 32'(edges[1]), 32'd0);

    // overflow: 20-wide lines; AW=4 instance drops cols >= 16
    clear_pix();
    for (int r = 0; r < 8; r++) pix[r][2] = S;
    pix[3][17] = S;
    run_frame(20, 8, 1'b0);
    chk("ovf_edges_a", 32'(edges[0]), 32'd7);
    chk("ovf_edges_b", 32'(edges[1]), 32'd6);

    for (int k = 0; k < 3; k++) begin
      rand_frame(w, h);
      run_frame(w, h, 1'b0);
    end

    // reset in the middle of a line, then clean frames
    rand_frame(w, h);
    run_frame(w, h, 1'b1);
    for (int k = 0; k < 2; k++) begin
      rand_frame(w, h);
      run_frame(w, h, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
